// File: rtl/reg_write_arb.sv
// reg_write_arb -- round-robin arbiter that merges four register write
// requesters onto two register-file write ports with a registered grant.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req[NREQ]                      write request per requester (held until ack)
//   req_addr[NREQ][4]              target register address per requester
//   req_data[NREQ][N]              write data per requester
//   ack[NREQ]                      one-cycle acknowledge, exactly the set granted last cycle
//   write_address/data/enable      register-file write port 1
//   write_address2/data2/enable2   register-file write port 2
//   pc_update, pc_write            PC write port (tied to 0 unless ARB_PC_PORT_EN)
//   busy                           a request is pending that is not acknowledged this cycle
//
// Optional feature macro: ARB_PC_PORT_EN -- routes address-15 requests to the
// PC write port, granted independently of ports 1/2.

module reg_write_arb #(
   parameter int N    = 32,
   parameter int NREQ = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0][3:0]     req_addr,
   input  logic [NREQ-1:0][N-1:0]   req_data,
   output logic [NREQ-1:0]          ack,
   output logic [3:0]               write_address,
   output logic [N-1:0]             write_data,
   output logic                     write_enable,
   output logic [3:0]               write_address2,
   output logic [N-1:0]             write_data2,
   output logic                     write_enable2,
   output logic [N-1:0]             pc_update,
   output logic                     pc_write,
   output logic                     busy
);

   logic [1:0]      ptr;
   logic [NREQ-1:0] elig;       // eligible for ports 1/2
   logic [NREQ-1:0] elig_pc;    // eligible for the PC port
   logic [NREQ-1:0] grant;
   logic            g1_v, g2_v, pc_v;
   logic [1:0]      g1, g2, pc_idx;
   logic [1:0]      last_off;
   logic [1:0]      ptr_next;

   // The ack register doubles as the mask: a requester acknowledged this
   // cycle has not yet dropped its request and must not be granted again.
`ifdef ARB_PC_PORT_EN
   logic [NREQ-1:0] is_pc;
   always_comb begin
      is_pc = '0;
      for (int unsigned i = 0; i < NREQ; i++) is_pc[i] = (req_addr[i] == 4'hF);
   end
   assign elig    = req & ~ack & ~is_pc;
   assign elig_pc = req & ~ack & is_pc;
`else
   assign elig    = req & ~ack;
   assign elig_pc = '0;
`endif

   // Single pass in search order from ptr. Grants are found in increasing
   // offset, so the last grant seen is the one the pointer moves past.
   always_comb begin
      logic [1:0] idx;
      idx      = '0;
      g1_v     = 1'b0;
      g2_v     = 1'b0;
      pc_v     = 1'b0;
      g1       = '0;
      g2       = '0;
      pc_idx   = '0;
      last_off = '0;
      grant    = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = ptr + 2'(k);
         if (elig[idx]) begin
            if (!g1_v) begin
               g1_v     = 1'b1;
               g1       = idx;
               last_off = 2'(k);
               grant[idx] = 1'b1;
            end else if (!g2_v && (req_addr[idx] != req_addr[g1])) begin
               g2_v     = 1'b1;
               g2       = idx;
               last_off = 2'(k);
               grant[idx] = 1'b1;
            end
         end
         if (elig_pc[idx] && !pc_v) begin
            pc_v     = 1'b1;
            pc_idx   = idx;
            last_off = 2'(k);
            grant[idx] = 1'b1;
         end
      end
      ptr_next = ptr + last_off + 2'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr            <= '0;
         ack            <= '0;
         write_enable   <= 1'b0;
         write_address  <= '0;
         write_data     <= '0;
         write_enable2  <= 1'b0;
         write_address2 <= '0;
         write_data2    <= '0;
      end else begin
         ack           <= grant;
         write_enable  <= g1_v;
         write_enable2 <= g2_v;
         if (g1_v) begin
            write_address <= req_addr[g1];
            write_data    <= req_data[g1];
         end
         if (g2_v) begin
            write_address2 <= req_addr[g2];
            write_data2    <= req_data[g2];
         end
         if (g1_v || pc_v) ptr <= ptr_next;
      end
   end

`ifdef ARB_PC_PORT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_write  <= 1'b0;
         pc_update <= '0;
      end else begin
         pc_write <= pc_v;
         if (pc_v) pc_update <= req_data[pc_idx];
      end
   end
`else
   assign pc_write  = 1'b0;
   assign pc_update = '0;
`endif

   assign busy = |(req & ~ack);

endmodule

// File: doc/reg_write_arb.md
REG_WRITE_ARB -- requirements
Module: reg_write_arb

Interface
REQ-001 Parameter: N, default 32, register data width.
REQ-002 Parameter: NREQ, fixed 4, number of write requesters (indices 0..3).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req  input  4  per-requester write request; held high until acknowledged.
REQ-006 req_addr  input  4x4  per-requester target register address, stable while req high.
REQ-007 req_data  input  4xN  per-requester write data, stable while req high.
REQ-008 ack  output  4  per-requester one-cycle grant acknowledge.
REQ-009 write_address, write_data, write_enable  output  4/N/1  register-file write port 1.
REQ-010 write_address2, write_data2, write_enable2  output  4/N/1  register-file write port 2.
REQ-011 pc_update, pc_write  output  N/1  register-file PC write port (driven only with ARB_PC_PORT_EN).
REQ-012 busy  output  1  high while any req bit is high and not being acknowledged this cycle.

Function
REQ-013 Arbitration SHALL be evaluated every cycle over eligible requesters: req high and not masked.
REQ-014 Search order SHALL be round-robin: ptr, ptr+1, ... ptr+3 (mod 4).
REQ-015 First eligible requester in search order SHALL win port 1; next eligible requester with a different address SHALL win port 2.
REQ-016 An eligible requester whose address equals the port-1 winner's address SHALL NOT be granted this cycle; the search continues past it.
REQ-017 Grants SHALL be registered: a grant decided in cycle t drives write_enable/address/data and ack in cycle t+1 (latency 1).
REQ-018 Outputs SHALL change only on posedge clk so that they are stable at the register file's negedge sample.
REQ-019 A requester acknowledged in cycle t+1 SHALL be masked from arbitration during cycle t+1 (the requester drops or replaces its request after the ack).
REQ-020 ptr SHALL advance to (index of last requester granted this cycle)+1 mod 4; ptr SHALL hold if nothing is granted.
REQ-021 With no grant, write_enable and write_enable2 SHALL be 0 and addresses/data SHALL hold their previous values.
REQ-022 Port 2 SHALL only be used when port 1 is used; a single grant always goes to port 1.
REQ-023 At most one ack per requester per cycle; ack bits SHALL be exactly the set granted the previous cycle.

Reset
REQ-024 rst_n low SHALL immediately clear ack, write_enable, write_enable2, pc_write, all addresses, data, pc_update, ptr and mask to 0.
REQ-025 Reset asserted mid-transfer SHALL drop any pending grant; requesters re-arbitrate after release starting from ptr=0.
REQ-026 First arbitration after rst_n rises SHALL occur on the first posedge with rst_n high.

Configuration
REQ-027 Macro ARB_PC_PORT_EN: when defined, a request with address 15 SHALL be routed to pc_write/pc_update, granted independently of ports 1/2, with at most one PC grant per cycle (first in round-robin order); ptr updates consider all granted requesters.
REQ-028 Without ARB_PC_PORT_EN, address 15 SHALL be arbitrated as an ordinary address on ports 1/2, and pc_write/pc_update SHALL be tied to 0.

Verification
REQ-029 Reset, req=4'b1111 addresses 1,2,3,4 -> cycle+1: ack=0011, ports write R1,R2; cycle+2: ack=1100, ports write R3,R4; ptr=0.
REQ-030 req0 and req1 both address 5 (data A, B) -> cycle+1: only ack0, port1 R5=A, write_enable2=0; cycle+2: ack1, R5=B.
REQ-031 req2 held high continuously for 8 cycles alongside req0 -> req2 acknowledged at least once every 2 cycles (no starvation).
REQ-032 With ARB_PC_PORT_EN, req0 addr 15 data 0x100, req1 addr 3, req2 addr 4 -> single cycle: pc_write=1 pc_update=0x100, ports write R3,R4, ack=0111.
REQ-033 rst_n pulsed low while write_enable=1 -> write_enable and ack drop to 0 asynchronously; after release, arbitration restarts from requester 0.
REQ-034 req=0 for 5 cycles -> write_enable, write_enable2, ack, busy stay 0; ptr unchanged.
